// File: rtl/rvecc_encode_pipe.sv
// SECDED encoder (Hamming + overall parity) behind a STAGES-deep elastic pipeline, with one-shot fault injection and a saturating output word count.
// Latency: STAGES cycles at one word per cycle. Backpressure: a stall on out_ready fills the pipeline, then in_ready drops.
module rvecc_encode_pipe #(
  parameter int  DW     = 32,
  parameter int  STAGES = 1,
  parameter int  CNTW   = 16,
  localparam int ECCW   = (DW == 64) ? 8 : 7
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [ECCW-1:0]      out_ecc,
  input  logic                 inj_arm,
  input  logic [DW+ECCW-1:0]   inj_mask,
  output logic                 inj_pending,
  output logic [CNTW-1:0]      word_cnt
);

  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $error("rvecc_encode_pipe: DW must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("rvecc_encode_pipe: STAGES must be 1 or 2");
  end

  // Row i selects the data bits whose codeword position has bit i set;
  // data fills the non-power-of-two positions 1..DW+ECCW-1, LSB first.
  function automatic logic [ECCW-2:0][DW-1:0] calc_cover();
    logic [ECCW-2:0][DW-1:0] cov;
    int                      j;
    cov = '0;
    j   = 0;
    for (int p = 1; p < DW + ECCW; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int i = 0; i < ECCW - 1; i++) begin
          if (p[i]) cov[i][j] = 1'b1;
        end
        j++;
      end
    end
    return cov;
  endfunction

  localparam logic [ECCW-2:0][DW-1:0] COVER = calc_cover();

  logic [ECCW-2:0] enc_chk;
  logic [ECCW-1:0] enc_ecc;
  logic            in_hs;
  logic            inj_apply;
  logic [DW-1:0]   in_dat_inj;
  logic [ECCW-1:0] in_ecc_inj;
  logic            inj_q, inj_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [STAGES-1:0]           vld_vec;
  logic [STAGES-1:0][DW-1:0]   dat_vec;
  logic [STAGES-1:0][ECCW-1:0] ecc_vec;
  logic [STAGES-1:0]           stg_rdy;

  always_comb begin
    enc_chk = '0;
    for (int i = 0; i < ECCW - 1; i++) begin
      enc_chk[i] = ^(in_data & COVER[i]);
    end
  end

  assign enc_ecc    = {^{in_data, enc_chk}, enc_chk};
  assign in_hs      = in_valid && in_ready;
  assign inj_apply  = in_hs && inj_q;
  assign in_dat_inj = in_data ^ (inj_apply ? inj_mask[DW-1:0] : '0);
  assign in_ecc_inj = enc_ecc ^ (inj_apply ? inj_mask[DW+ECCW-1:DW] : '0);

  // Unrolled form of ready_k = !valid_k || ready_(k+1): a stage can move
  // whenever the sink accepts or any stage at or after it has a hole.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld_vec[j]) stg_rdy[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic            vld_q;
    logic [DW-1:0]   dat_q;
    logic [ECCW-1:0] ecc_q;
    logic            src_vld;
    logic [DW-1:0]   src_dat;
    logic [ECCW-1:0] src_ecc;

    if (k == 0) begin : g_head
      assign src_vld = in_valid;
      assign src_dat = in_dat_inj;
      assign src_ecc = in_ecc_inj;
    end else begin : g_body
      assign src_vld = vld_vec[k-1];
      assign src_dat = dat_vec[k-1];
      assign src_ecc = ecc_vec[k-1];
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        ecc_q <= '0;
      end else if (stg_rdy[k]) begin
        vld_q <= src_vld;
        if (src_vld) begin
          dat_q <= src_dat;
          ecc_q <= src_ecc;
        end
      end
    end

    assign vld_vec[k] = vld_q;
    assign dat_vec[k] = dat_q;
    assign ecc_vec[k] = ecc_q;
  end

  // A consuming handshake re-arms only if inj_arm is high in that same cycle.
  always_comb begin
    inj_d = inj_q;
    if (in_hs && inj_q) begin
      inj_d = inj_arm;
    end else if (inj_arm) begin
      inj_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      inj_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      inj_q <= inj_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready    = stg_rdy[0];
  assign out_valid   = vld_vec[STAGES-1];
  assign out_data    = dat_vec[STAGES-1];
  assign out_ecc     = ecc_vec[STAGES-1];
  assign inj_pending = inj_q;
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_rvecc_encode_pipe.sv
// Bench for rvecc_encode_pipe: three configurations (32b/1 stage, 64b/2 stages, 32b/2 stages with 4-bit counter).
module tb_rvecc_encode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: DW=32 STAGES=1 CNTW=16
  logic        a_rst_l, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_inj_arm, a_inj_pending;
  logic [31:0] a_in_data, a_out_data;
  logic [6:0]  a_out_ecc;
  logic [38:0] a_inj_mask;
  logic [15:0] a_word_cnt;
  // B: DW=64 STAGES=2 CNTW=16
  logic        b_rst_l, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_inj_arm, b_inj_pending;
  logic [63:0] b_in_data, b_out_data;
  logic [7:0]  b_out_ecc;
  logic [71:0] b_inj_mask;
  logic [15:0] b_word_cnt;
  // C: DW=32 STAGES=2 CNTW=4
  logic        c_rst_l, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_inj_arm, c_inj_pending;
  logic [31:0] c_in_data, c_out_data;
  logic [6:0]  c_out_ecc;
  logic [38:0] c_inj_mask;
  logic [3:0]  c_word_cnt;

  rvecc_encode_pipe #(.DW(32), .STAGES(1), .CNTW(16)) u_a (
    .clk(clk), .rst_l(a_rst_l), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ecc(a_out_ecc),
    .inj_arm(a_inj_arm), .inj_mask(a_inj_mask), .inj_pending(a_inj_pending), .word_cnt(a_word_cnt));

  rvecc_encode_pipe #(.DW(64), .STAGES(2), .CNTW(16)) u_b (
    .clk(clk), .rst_l(b_rst_l), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ecc(b_out_ecc),
    .inj_arm(b_inj_arm), .inj_mask(b_inj_mask), .inj_pending(b_inj_pending), .word_cnt(b_word_cnt));

  rvecc_encode_pipe #(.DW(32), .STAGES(2), .CNTW(4)) u_c (
    .clk(clk), .rst_l(c_rst_l), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_ecc(c_out_ecc),
    .inj_arm(c_inj_arm), .inj_mask(c_inj_mask), .inj_pending(c_inj_pending), .word_cnt(c_word_cnt));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Hamming property: XOR of the codeword positions of all set data bits equals the check bits.
  function automatic logic [7:0] ref_ecc(input logic [63:0] d, input int dw);
    int         syn, pos, j, eccw;
    logic [7:0] e;
    eccw = (dw == 64) ? 8 : 7;
    syn = 0; pos = 0; j = 0;
    while (j < dw) begin
      pos++;
      if ((pos & (pos - 1)) != 0) begin
        if (d[j]) syn = syn ^ pos;
        j++;
      end
    end
    e = 8'(syn);
    e[eccw-1] = (^d) ^ (^e);
    return e;
  endfunction

  // Full-codeword decode: syndrome over all positions and overall parity must both be zero.
  function automatic logic secded_clean(input logic [63:0] d, input logic [7:0] e, input int dw);
    int syn, pos, j, eccw;
    eccw = (dw == 64) ? 8 : 7;
    syn = 0; pos = 0; j = 0;
    for (int i = 0; i < eccw - 1; i++) begin
      if (e[i]) syn = syn ^ (1 << i);
    end
    while (j < dw) begin
      pos++;
      if ((pos & (pos - 1)) != 0) begin
        if (d[j]) syn = syn ^ pos;
        j++;
      end
    end
    return (syn == 0) && (((^d) ^ (^e)) == 1'b0);
  endfunction

  typedef struct packed {
    logic [31:0] data;
    logic [6:0]  ecc;
  } vec_t;
  vec_t vt [5];

  logic [63:0] exp_q [$];
  logic [63:0] exp_d;
  int          sent, rcvd, occ, cycles;
  logic        prev_stall, drop_seen;
  logic [31:0] prev_dat;
  logic [6:0]  prev_ecc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{data: 32'h0000_0000, ecc: 7'h00};
    vt[1] = '{data: 32'h0000_0001, ecc: 7'h43};
    vt[2] = '{data: 32'hFFFF_FFFF, ecc: 7'h18};
    vt[3] = '{data: 32'h8000_0000, ecc: 7'h26};
    vt[4] = '{data: 32'h0000_0002, ecc: 7'h45};

    a_rst_l = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_inj_arm = 0; a_inj_mask = 0;
    b_rst_l = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_inj_arm = 0; b_inj_mask = 0;
    c_rst_l = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 1; c_inj_arm = 0; c_inj_mask = 0;

    #2;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_ecc", a_out_ecc, 0);
    check("rst_a_inj_pending", a_inj_pending, 0);
    check("rst_a_word_cnt", a_word_cnt, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_ecc", b_out_ecc, 0);
    check("rst_c_in_ready", c_in_ready, 1);
    #20;
    a_rst_l = 1; b_rst_l = 1; c_rst_l = 1;

    // Known vectors, one cycle after acceptance, back to back
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      a_in_valid = 1; a_in_data = vt[v].data;
      @(posedge clk); #1;
      check("vec_out_valid", a_out_valid, 1);
      check("vec_out_data", a_out_data, vt[v].data);
      check("vec_out_ecc", a_out_ecc, vt[v].ecc);
    end
    @(negedge clk); a_in_valid = 0;
    @(posedge clk); #1;
    check("vec_idle_valid", a_out_valid, 0);
    check("vec_word_cnt", a_word_cnt, 5);

    // One-shot injection and its re-arm rules
    @(negedge clk); a_inj_arm = 1;
    @(negedge clk); a_inj_arm = 0;
    check("inj_armed", a_inj_pending, 1);
    a_in_valid = 1; a_in_data = 32'h1; a_inj_mask = 39'h1;
    @(posedge clk); #1;
    check("inj_data", a_out_data, 32'h0);
    check("inj_ecc", a_out_ecc, 7'h43);
    check("inj_cleared", a_inj_pending, 0);
    @(negedge clk);
    @(posedge clk); #1;
    check("inj_next_data", a_out_data, 32'h1);
    check("inj_next_ecc", a_out_ecc, 7'h43);
    @(negedge clk); a_in_valid = 0; a_inj_arm = 1;
    @(negedge clk); a_in_valid = 1; a_in_data = 32'h1; a_inj_mask = 39'h1 << 32;
    @(posedge clk); #1;
    check("rearm_data", a_out_data, 32'h1);
    check("rearm_ecc", a_out_ecc, 7'h42);
    check("rearm_pending", a_inj_pending, 1);
    @(negedge clk); a_inj_arm = 0; a_in_data = 32'h2; a_inj_mask = 39'h20;
    @(posedge clk); #1;
    check("rearm2_data", a_out_data, 32'h22);
    check("rearm2_ecc", a_out_ecc, 7'h45);
    check("rearm2_pending", a_inj_pending, 0);
    @(negedge clk); a_inj_arm = 1; a_in_data = 32'h0; a_inj_mask = '1;
    @(posedge clk); #1;
    check("arm_hs_data", a_out_data, 32'h0);
    check("arm_hs_ecc", a_out_ecc, 7'h00);
    check("arm_hs_pending", a_inj_pending, 1);
    @(negedge clk); a_inj_arm = 0; a_inj_mask = {7'h00, 32'hFFFF_FFFF};
    @(posedge clk); #1;
    check("arm_hs2_data", a_out_data, 32'hFFFF_FFFF);
    check("arm_hs2_ecc", a_out_ecc, 7'h00);
    check("arm_hs2_pending", a_inj_pending, 0);
    @(negedge clk); a_in_valid = 0;

    // 64-bit, 2 stages: latency then randomized stream
    @(negedge clk); b_in_valid = 1; b_in_data = 64'h1;
    @(posedge clk); #1;
    check("b_lat_early", b_out_valid, 0);
    @(negedge clk); b_in_valid = 0;
    @(posedge clk); #1;
    check("b_lat_valid", b_out_valid, 1);
    check("b_lat_ecc", b_out_ecc, 8'h83);
    check("b_lat_data", b_out_data, 64'h1);
    @(posedge clk); #1;
    check("b_cnt_one", b_word_cnt, 1);

    sent = 0; rcvd = 0; cycles = 0;
    exp_q.delete();
    while ((sent < 1000 || rcvd < sent) && cycles < 8000) begin
      @(negedge clk);
      cycles++;
      b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b_in_data   = {$urandom, $urandom};
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          check("b_rand_extra_word", 1, 0);
        end else begin
          exp_d = exp_q.pop_front();
          check("b_rand_data", b_out_data, exp_d);
          check("b_rand_ecc", b_out_ecc, ref_ecc(exp_d, 64));
          check("b_rand_syndrome", secded_clean(b_out_data, b_out_ecc, 64), 1);
        end
        rcvd++;
      end
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(b_in_data);
        sent++;
      end
    end
    @(negedge clk); b_in_valid = 0; b_out_ready = 0;
    check("b_rand_received", rcvd, 1000);
    check("b_word_cnt", b_word_cnt, 1001);

    // 2-stage stall: in_ready only drops when full, outputs hold, order kept
    sent = 0; rcvd = 0; prev_stall = 0; drop_seen = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      c_in_valid  = (sent < 8);
      c_in_data   = 32'hC0DE_0000 | 32'(sent);
      c_out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      occ = sent - rcvd;
      check("c_in_ready", c_in_ready, (occ < 2) || c_out_ready);
      if (!c_in_ready) drop_seen = 1;
      if (prev_stall) begin
        check("c_hold_valid", c_out_valid, 1);
        check("c_hold_data", c_out_data, prev_dat);
        check("c_hold_ecc", c_out_ecc, prev_ecc);
      end
      if (c_out_valid && c_out_ready) begin
        if (exp_q.size() == 0) begin
          check("c_extra_word", 1, 0);
        end else begin
          exp_d = exp_q.pop_front();
          check("c_order_data", c_out_data, exp_d);
          check("c_order_ecc", c_out_ecc, ref_ecc(exp_d, 32));
        end
        rcvd++;
      end
      if (c_in_valid && c_in_ready) begin
        exp_q.push_back({32'h0, c_in_data});
        sent++;
      end
      prev_stall = c_out_valid && !c_out_ready;
      prev_dat   = c_out_data;
      prev_ecc   = c_out_ecc;
    end
    @(negedge clk); c_in_valid = 0;
    check("c_received", rcvd, 8);
    check("c_ready_dropped", drop_seen, 1);
    check("c_word_cnt_8", c_word_cnt, 8);

    // Counter saturation at 15 for a 4-bit counter
    for (int w = 0; w < 12; w++) begin
      @(negedge clk); c_in_valid = 1; c_in_data = $urandom;
    end
    @(negedge clk); c_in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("c_idle_valid", c_out_valid, 0);
    check("c_word_cnt_sat", c_word_cnt, 15);

    // Asynchronous reset with both stages full and an injection pending
    @(negedge clk); c_out_ready = 0; c_in_valid = 1; c_in_data = 32'h1111_1111;
    @(negedge clk); c_in_data = 32'h2222_2222;
    @(negedge clk); c_in_valid = 0; c_inj_arm = 1;
    @(negedge clk); c_inj_arm = 0;
    #1;
    check("full_in_ready", c_in_ready, 0);
    check("full_out_valid", c_out_valid, 1);
    check("full_inj_pending", c_inj_pending, 1);
    #2; c_rst_l = 0;
    #1;
    check("arst_out_valid", c_out_valid, 0);
    check("arst_inj_pending", c_inj_pending, 0);
    check("arst_word_cnt", c_word_cnt, 0);
    check("arst_in_ready", c_in_ready, 1);
    check("arst_out_data", c_out_data, 0);
    check("arst_out_ecc", c_out_ecc, 0);
    #10; c_rst_l = 1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
